instr_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the 16-bit Harvard core: fetches a 32-bit instruction word,

---
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/dispatch sequencer for the 16-bit Harvard core
module instr_sequencer #(
    parameter int PC_W  = 8,
    parameter int OPC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr,
    output logic            alu_start,
    output logic [3:0]      alu_op,
    input  logic            alu_done,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we2,
    output logic            rf_we1,
    output logic [1:0]      wb_sel,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              illegal_q, illegal_d;
    // Marks the first EXEC cycle so alu_start is a single pulse even while the ALU stalls.
    logic              first_q, first_d;

    logic [OPC_W-1:0]  opcode;
    logic              op_is_wb;
    logic              op_is_mem;
    logic              op_is_alu;
    logic              op_is_store;

    // Opcode classification from the held instruction register.
    always_comb begin
        opcode      = instr_q[31:32-OPC_W];
        op_is_wb    = (opcode <= OPC_W'(1));
        op_is_mem   = (opcode == OPC_W'(2)) || (opcode == OPC_W'(3));
        op_is_alu   = (opcode >= OPC_W'(4)) && (opcode <= OPC_W'(16));
        op_is_store = (opcode == OPC_W'(3));
    end

    // Next-state, pc/instr updates and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        first_d   = 1'b0;
        imem_req  = 1'b0;
        imem_addr = '0;
        alu_start = 1'b0;
        alu_op    = 4'd0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we2    = 1'b0;
        rf_we1    = 1'b0;
        wb_sel    = 2'd0;
        instr     = instr_q;
        illegal   = illegal_q;
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_is_wb) begin
                    state_d = S_WB;
                end else if (op_is_mem) begin
                    state_d = S_MEM;
                end else if (op_is_alu) begin
                    state_d = S_EXEC;
                    first_d = 1'b1;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                alu_start = first_q;
                // opcode 16 maps to function 12; the low nibble minus 4 gives that modulo 16.
                alu_op    = opcode[3:0] - 4'd4;
                if (alu_done) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op_is_store;
                if (dmem_ack) begin
                    if (op_is_store) begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we2 = 1'b1;
                rf_we1 = op_is_alu;
                if (op_is_alu) begin
                    wb_sel = 2'd3;
                end else begin
                    wb_sel = opcode[1:0];
                end
                pc_d    = pc_q + PC_W'(1);
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset overrides everything, including pending handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            first_q   <= first_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic        alu_done;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we2;
    logic        rf_we1;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        busy;

    instr_sequencer #(.PC_W(8), .OPC_W(6)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we2(rf_we2), .rf_we1(rf_we1), .wb_sel(wb_sel), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req;
        logic [7:0]  imem_addr;
        logic        alu_start;
        logic [3:0]  alu_op;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we2;
        logic        rf_we1;
        logic [1:0]  wb_sel;
        logic        illegal;
        logic        busy;
        logic [31:0] instr;
    } obs_t;

    // ph: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 idle
    typedef struct {
        obs_t        o;
        int          ph;
        bit          ack;
        logic [31:0] word;
    } step_t;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  df;
        logic [3:0]  dd;
        logic [7:0]  len;
        logic [3:0]  starts;
        logic [3:0]  aop;
        logic [3:0]  dmc;
        logic [3:0]  wec;
        logic [3:0]  we2c;
        logic [1:0]  wbs;
        logic        we1;
    } vec_t;

    int          n_pass = 0;
    int          n_tot  = 0;
    step_t       trace[$];
    int          m_pc;
    logic [31:0] m_ir;
    bit          noise_en;
    vec_t        vecs[9];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.imem_req = imem_req;  o.imem_addr = imem_addr; o.alu_start = alu_start;
        o.alu_op = alu_op;      o.dmem_req = dmem_req;   o.dmem_we = dmem_we;
        o.rf_we2 = rf_we2;      o.rf_we1 = rf_we1;       o.wb_sel = wb_sel;
        o.illegal = illegal;    o.busy = busy;           o.instr = instr;
        return o;
    endfunction

    function automatic logic noise();
        return noise_en & 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_done = 1'b0;
        imem_data = 32'h0;
        tick();
        rst = 1'b0;
        m_pc = 0;
        m_ir = 32'h0;
    endtask

    // Expected per-cycle outputs of one instruction, from the opcode routing rules.
    task automatic build(input logic [31:0] w, input int df, input int dd);
        step_t s;
        int    opc;
        opc = int'(w[31:26]);
        for (int i = 0; i <= df; i++) begin
            s.o = '0; s.o.imem_req = 1'b1; s.o.imem_addr = 8'(m_pc); s.o.busy = 1'b1;
            s.o.instr = m_ir; s.ph = 0; s.ack = (i == df); s.word = w;
            trace.push_back(s);
        end
        m_ir = w;
        s.o = '0; s.o.busy = 1'b1; s.o.instr = w; s.ph = 1; s.ack = 1'b0;
        trace.push_back(s);
        if (opc == 2 || opc == 3) begin
            for (int i = 0; i <= dd; i++) begin
                s.o = '0; s.o.busy = 1'b1; s.o.instr = w; s.o.dmem_req = 1'b1;
                s.o.dmem_we = (opc == 3); s.ph = 3; s.ack = (i == dd);
                trace.push_back(s);
            end
        end
        if (opc >= 4) begin
            for (int i = 0; i <= dd; i++) begin
                s.o = '0; s.o.busy = 1'b1; s.o.instr = w; s.o.alu_start = (i == 0);
                s.o.alu_op = 4'(opc - 4); s.ph = 2; s.ack = (i == dd);
                trace.push_back(s);
            end
        end
        if (opc != 3) begin
            s.o = '0; s.o.busy = 1'b1; s.o.instr = w; s.o.rf_we2 = 1'b1;
            s.o.rf_we1 = (opc >= 4); s.o.wb_sel = (opc >= 4) ? 2'd3 : 2'(opc);
            s.ph = 4; s.ack = 1'b0;
            trace.push_back(s);
        end
        m_pc = (m_pc + 1) % 256;
    endtask

    task automatic run_trace();
        step_t s;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            check("trace", 64'(sample()), 64'(s.o));
            imem_ack  = (s.ph == 0) ? s.ack : noise();
            imem_data = (s.ph == 0 && s.ack) ? s.word : $urandom();
            dmem_ack  = (s.ph == 3) ? s.ack : noise();
            alu_done  = (s.ph == 2) ? s.ack : noise();
            tick();
        end
    endtask

    task automatic push_idle();
        step_t s;
        s.o = '0; s.o.instr = m_ir; s.ph = 5; s.ack = 1'b0; s.word = 32'h0;
        trace.push_back(s);
    endtask

    initial begin
        vec_t v;
        int c, fcnt, mcnt, a_cnt;
        bit a_act, done;
        logic [3:0] starts, aop, dmc, wec, we2c;
        logic [1:0] wbs;
        logic we1;
        logic [7:0] start;

        // word, df, dd, len, starts, alu_op, dmem cycles, store cycles, rf_we2 count, wb_sel, rf_we1
        vecs[0] = '{32'h0000_1234, 4'd0, 4'd0, 8'd3, 4'd0, 4'd0,  4'd0, 4'd0, 4'd1, 2'd0, 1'b0};
        vecs[1] = '{32'h0400_0000, 4'd0, 4'd0, 8'd3, 4'd0, 4'd0,  4'd0, 4'd0, 4'd1, 2'd1, 1'b0};
        vecs[2] = '{32'h0800_0000, 4'd0, 4'd0, 8'd4, 4'd0, 4'd0,  4'd1, 4'd0, 4'd1, 2'd2, 1'b0};
        vecs[3] = '{32'h0C00_0000, 4'd0, 4'd2, 8'd5, 4'd0, 4'd0,  4'd3, 4'd3, 4'd0, 2'd0, 1'b0};
        vecs[4] = '{32'h1000_0000, 4'd0, 4'd3, 8'd7, 4'd1, 4'd0,  4'd0, 4'd0, 4'd1, 2'd3, 1'b1};
        vecs[5] = '{32'h4000_0000, 4'd0, 4'd0, 8'd4, 4'd1, 4'd12, 4'd0, 4'd0, 4'd1, 2'd3, 1'b1};
        vecs[6] = '{32'h0800_0000, 4'd0, 4'd2, 8'd6, 4'd0, 4'd0,  4'd3, 4'd0, 4'd1, 2'd2, 1'b0};
        vecs[7] = '{32'h0000_0000, 4'd2, 4'd0, 8'd5, 4'd0, 4'd0,  4'd0, 4'd0, 4'd1, 2'd0, 1'b0};
        vecs[8] = '{32'h2C00_ABCD, 4'd0, 4'd1, 8'd5, 4'd1, 4'd7,  4'd0, 4'd0, 4'd1, 2'd3, 1'b1};

        noise_en = 1'b0;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_done = 1'b0; imem_data = 32'h0;
        @(negedge clk);
        do_reset();
        check("reset_outputs", 64'(sample()), 64'h0);
        tick(); tick();
        check("idle_hold", 64'(sample()), 64'h0);

        // Directed table, run=1, acks driven reactively from the DUT requests.
        run = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            v = vecs[k];
            start = imem_addr;
            c = 0; fcnt = 0; mcnt = 0; a_cnt = 0; a_act = 0; done = 0;
            starts = 0; aop = 0; dmc = 0; wec = 0; we2c = 0; wbs = 0; we1 = 0;
            while (!done && c < 40) begin
                if (c > 0 && imem_req && imem_addr != start) begin
                    done = 1;
                end else begin
                    if (alu_start) begin starts++; aop = alu_op; a_act = 1; a_cnt = 0; end
                    else if (a_act) a_cnt++;
                    if (dmem_req) begin dmc++; if (dmem_we) wec++; end
                    if (rf_we2) begin we2c++; wbs = wb_sel; we1 = rf_we1; end
                    imem_ack  = imem_req && (fcnt == int'(v.df));
                    imem_data = v.word;
                    if (imem_req) fcnt++;
                    dmem_ack  = dmem_req && (mcnt == int'(v.dd));
                    if (dmem_req) mcnt++;
                    alu_done  = a_act && (a_cnt == int'(v.dd));
                    if (alu_done) a_act = 0;
                    tick();
                    c++;
                end
            end
            imem_ack = 1'b0; dmem_ack = 1'b0; alu_done = 1'b0;
            check($sformatf("vec%0d_len", k), 64'(c), 64'(v.len));
            check($sformatf("vec%0d_obs", k), 64'({starts, aop, dmc, wec, we2c, wbs, we1}),
                  64'({v.starts, v.aop, v.dmc, v.wec, v.we2c, v.wbs, v.we1}));
            check($sformatf("vec%0d_next_addr", k), 64'(imem_addr), 64'(start + 8'd1));
        end

        // Illegal opcode: HALT is sticky until reset.
        do_reset();
        run = 1'b1;
        tick();
        imem_data = 32'h4400_0000; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        noise_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("halt_outputs", 64'({imem_req, busy, illegal, dmem_req, alu_start, rf_we2}), 64'(6'b001000));
            imem_ack = noise(); dmem_ack = noise(); alu_done = noise();
            tick();
        end
        check("halt_instr", 64'(instr), 64'h4400_0000);
        noise_en = 1'b0;
        do_reset();
        check("halt_rst_clears", 64'(sample()), 64'h0);

        // run dropped while a load waits on memory.
        run = 1'b1;
        tick();
        imem_data = 32'h0800_0000; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        run = 1'b0;
        tick(); tick();
        check("load_wait_req", 64'({dmem_req, dmem_we, busy}), 64'(3'b101));
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("load_wb", 64'({rf_we2, rf_we1, wb_sel, busy}), 64'(5'b10101));
        tick();
        check("run_drop_idle", 64'({busy, imem_req, dmem_req}), 64'(3'b000));
        tick();
        check("run_drop_idle2", 64'(busy), 64'(1'b0));
        run = 1'b1;
        tick();
        check("resume_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 8'd1}));

        // Reset during a store wait; the late ack must be ignored.
        do_reset();
        run = 1'b1;
        tick();
        imem_data = 32'h0C00_0000; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        check("store_wait", 64'({dmem_req, dmem_we}), 64'(2'b11));
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0; dmem_ack = 1'b1;
        check("rst_in_mem", 64'(sample()), 64'h0);
        tick();
        dmem_ack = 1'b0;
        check("late_ack_ignored", 64'(sample()), 64'h0);
        run = 1'b1;
        tick();
        check("rst_pc_zero", 64'({imem_req, imem_addr, instr}), 64'({1'b1, 8'd0, 32'h0}));

        // Reference-model runs: 256 op1 to wrap pc, then randomized traffic, with ack noise.
        do_reset();
        noise_en = 1'b1;
        run = 1'b1;
        push_idle();
        for (int k = 0; k < 256; k++) begin
            build({6'd1, 26'($urandom)}, 0, 0);
            run_trace();
            if (k == 254) check("wrap_addr_255", 64'(imem_addr), 64'd255);
            if (k == 255) check("wrap_addr_0", 64'(imem_addr), 64'd0);
        end
        for (int k = 0; k < 150; k++) begin
            build({6'($urandom_range(0, 16)), 26'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3));
            run_trace();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
